// File: rtl/layer_seq_pkg.sv
// Shared fixed-point format, activation codes and FSM encoding for sequenced layers.
package layer_seq_pkg;

  localparam int unsigned N = 32;         // data width
  localparam int unsigned F = 24;         // fraction bits
  localparam int unsigned I = N - F - 1;  // integer bits (excluding sign)

  localparam logic ACT_RELU = 1'b0;
  localparam logic ACT_LIN  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAcc,
    StOut,
    StDone
  } state_e;

endpackage

// File: rtl/seq_mac.sv
// Sequenced multiply-accumulate node: 2N-bit accumulator with bias load,
// truncation back to the fixed-point format and selectable activation.
module seq_mac
  import layer_seq_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         acc_en_i,
  input  logic         load_bias_i,
  input  logic         capture_i,
  input  logic         act_sel_i,
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] w_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] z_o,
  output logic [N-1:0] y_o
);

  localparam int unsigned AW = 2 * N;

  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] bias_ext, prod, sum;
  logic [N-1:0]  z_next, y_next;
  logic [N-1:0]  z_q, y_q;

  always_comb begin
    bias_ext = {{(I + 1){b_i[N-1]}}, b_i, {F{1'b0}}};
    // Operands sign-extended to 2N so the low 2N bits hold the exact signed product.
    prod     = {{N{x_i[N-1]}}, x_i} * {{N{w_i[N-1]}}, w_i};
    sum      = (load_bias_i ? bias_ext : acc_q) + prod;
    acc_d    = acc_en_i ? sum : acc_q;
    z_next   = sum[2*F+I:F];
    y_next   = (act_sel_i == ACT_LIN || !z_next[N-1]) ? z_next : '0;
  end

  // Results are captured from the final sum so they appear in the cycle after the last product.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      z_q   <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (capture_i) begin
        z_q <= z_next;
        y_q <= y_next;
      end
    end
  end

  assign z_o = z_q;
  assign y_o = y_q;

endmodule

// File: rtl/layer_seq.sv
// Fully connected layer evaluated one neuron at a time on a single MAC,
// fetching bias, inputs and weights from one-cycle-latency memories.
module layer_seq
  import layer_seq_pkg::*;
#(
  parameter  int unsigned SX = 2,
  parameter  int unsigned NN = 4,
  localparam int unsigned XW = (SX > 1) ? $clog2(SX) : 1,
  localparam int unsigned WW = (SX * NN > 1) ? $clog2(SX * NN) : 1,
  localparam int unsigned KW = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          act_sel,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_addr,
  input  logic [N-1:0]  x_data,
  output logic [WW-1:0] w_addr,
  input  logic [N-1:0]  w_data,
  output logic [KW-1:0] b_addr,
  input  logic [N-1:0]  b_data,
  output logic          y_valid,
  output logic [KW-1:0] y_idx,
  output logic [N-1:0]  y_data,
  output logic [N-1:0]  z_data
);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [XW-1:0] j_q, j_d;
  logic          act_q, act_d;
  logic [KW-1:0] y_idx_q;
  logic          j_last, k_last;
  logic [XW-1:0] x_sel;
  logic          acc_en, load_bias, capture;

  assign j_last = (j_q == XW'(SX - 1));
  assign k_last = (k_q == KW'(NN - 1));
  // Prefetch index j+1, holding on the last input so the address stays in range.
  assign x_sel  = j_last ? j_q : j_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StAcc;
      StAcc:   if (j_last) state_d = StOut;
      StOut:   state_d = k_last ? StDone : StLoad;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    y_valid   = 1'b0;
    x_addr    = '0;
    w_addr    = '0;
    b_addr    = '0;
    acc_en    = 1'b0;
    load_bias = 1'b0;
    capture   = 1'b0;
    case (state_q)
      StLoad: begin
        busy   = 1'b1;
        b_addr = k_q;
        w_addr = WW'(32'(k_q) * SX);
      end
      StAcc: begin
        busy      = 1'b1;
        b_addr    = k_q;
        x_addr    = x_sel;
        w_addr    = WW'(32'(k_q) * SX + 32'(x_sel));
        acc_en    = 1'b1;
        load_bias = (j_q == '0);
        capture   = j_last;
      end
      StOut: begin
        busy    = 1'b1;
        y_valid = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    k_d   = k_q;
    j_d   = j_q;
    act_d = act_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          k_d   = '0;
          act_d = act_sel;
        end
      end
      StLoad:  j_d = '0;
      StAcc:   if (!j_last) j_d = j_q + 1'b1;
      StOut:   if (!k_last) k_d = k_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      j_q     <= '0;
      act_q   <= ACT_RELU;
      y_idx_q <= '0;
    end else begin
      k_q   <= k_d;
      j_q   <= j_d;
      act_q <= act_d;
      if (capture) y_idx_q <= k_q;
    end
  end

  assign y_idx = y_idx_q;

  seq_mac u_mac (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .acc_en_i    (acc_en),
    .load_bias_i (load_bias),
    .capture_i   (capture),
    .act_sel_i   (act_q),
    .x_i         (x_data),
    .w_i         (w_data),
    .b_i         (b_data),
    .z_o         (z_data),
    .y_o         (y_data)
  );

endmodule

// File: doc/layer_seq.md
Name: layer_seq

Overview:
- Time-multiplexes one multiply-accumulate datapath across all neurons of a fully connected layer.
- For each neuron it reads bias, inputs and weights from synchronous memories, then accumulates one product per cycle.
- It truncates the result to the fixed-point format and applies the selected activation, then emits one result per neuron.
- Sits between the layer's weight/bias/input memories and the next layer's input buffer. Replaces NN parallel combinational nodes with one sequenced node.

Parameters:
- SX, 2, inputs per neuron (≥1)
- NN, 4, neurons in the layer (≥1)
- Data width n, fraction f and integer i come from fixed_point.vh; they are not parameters.

Ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin layer pass; sampled only in IDLE
- act_sel  in  1  0=ReLU, 1=linear; latched when start is accepted
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  one-cycle pulse at end of pass
- x_addr  out  max(1,$clog2(SX))  input memory read address
- x_data  in  n  input memory data, one-cycle read latency
- w_addr  out  max(1,$clog2(SX*NN))  weight address = k*SX+j
- w_data  in  n  weight data, one-cycle latency
- b_addr  out  max(1,$clog2(NN))  bias address = k
- b_data  in  n  bias data, one-cycle latency
- y_valid  out  1  one-cycle pulse, result valid
- y_idx  out  max(1,$clog2(NN))  neuron index of result
- y_data  out  n  activated output
- z_data  out  n  pre-activation sum

Behaviour:
- Reset (async, rst_n=0):
  - State→IDLE; counters k and j cleared; accumulator cleared.
  - All outputs 0, including addresses. act_sel latch cleared to ReLU.
- FSM states: IDLE, LOAD, ACC, OUT, DONE.
- IDLE:
  - start=1 → LOAD, k=0. busy=1 from LOAD onward.
- LOAD (1 cycle):
  - b_addr=k, x_addr=0, w_addr=k*SX. Go to ACC with j=0.
- ACC (SX cycles, j=0..SX-1):
  - Data for index j is present.
  - acc <= (j==0 ? bias_ext : acc) + x_data*w_data.
  - Addresses present j+1; they hold j=SX-1 on the last cycle.
  - j==SX-1 → OUT.
- OUT (1 cycle):
  - y_valid=1, y_idx=k, z_data=z, y_data=act(z).
  - If k==NN-1 → DONE; else k++ → LOAD.
- DONE (1 cycle):
  - done=1, busy=0 → IDLE.
- Latency:
  - Cycle 0 is the edge that accepts start.
  - Neuron k's OUT occurs in cycle (k+1)*(SX+2).
  - done occurs in cycle NN*(SX+2)+1.
  - The next start can be accepted in the cycle after done.
- Arithmetic:
  - Accumulator is 2n bits signed.
  - bias_ext = b_data sign-extended by i+1 bits and left-padded with f zero fraction bits.
  - Products are full 2n-bit signed.
  - Sums wrap modulo 2^(2n); there is no saturation.
  - z = acc[2f+i : f], i.e. truncation toward −inf on the fraction and wrap on the integer.
- Activation:
  - ReLU: y = (z<0) ? 0 : z; z==0 gives 0.
  - Linear: y = z.
- Output registers:
  - y_data, z_data and y_idx are registered and hold until the next OUT.
  - y_valid and done are pulses.
- Boundary rules:
  - start while not in IDLE is ignored; act_sel changes mid-pass are ignored.
  - SX=1 gives a single ACC cycle; NN=1 gives one OUT then DONE.
  - rst_n asserted in any state aborts immediately, with no partial y_valid. The next start restarts at neuron 0.
  - Memory data outside LOAD+1..ACC is ignored.

Decomposition:
- fixed_point.vh stays the shared package for n, f, i.
- Add to it: the act_sel codes (ACT_RELU=0, ACT_LIN=1) and the FSM state encodings.
- One sub-module, seq_mac, holds the 2n accumulator with load-bias/accumulate control and the truncation/activation output. It is reusable by later sequenced layers.
- layer_seq holds the FSM, the counters and the address generation.

Test Plan (fixed_point.vh at n=32, f=24):
- SX=2, NN=1; x={1.5,2.0}, w={0.5,−0.25}, b=0.125, ReLU → z=y=0.375 (0x00600000); y_valid in cycle 4; done in cycle 5.
- SX=2, NN=1; x={1.0,1.0}, w={−1.0,0.5}, b=0 → z=0xFF800000. ReLU gives y=0; a rerun with act_sel=1 gives y=0xFF800000.
- SX=2, NN=4, distinct weights → y_valid in cycles 4, 8, 12, 16 with y_idx 0..3. Each z matches the reference model; done in cycle 17; w_addr sequence is 0..7.
- Overflow: x=100.0, w=100.0, b=0, SX=1 → z wraps to 16.0 (0x10000000).
- start pulsed again in cycle 6 of a pass → ignored: pass timing unchanged, single done. A start in the cycle after done begins a new pass.
- rst_n low during ACC of neuron 2 → all outputs 0 asynchronously, no y_valid for neuron 2. A new start produces y_idx 0 first.
